// File: rtl/cfu_conv1d_engine.sv
// cfu_conv1d_engine: int8 1-D convolution engine on the CFU command/response port.
// Ports: clk, reset (sync, active-low), cmd_* command handshake, rsp_* response handshake.
module cfu_conv1d_engine #(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int MAX_LEN    = 1024,
    parameter int KERNEL_LEN = 8,
    parameter int LANES      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int AW   = $clog2(MAX_LEN);
    localparam int LW   = AW + 1;
    localparam int KAW  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
    localparam int P    = KERNEL_LEN / 2;
    localparam int YMAX = (1 << (DATA_W - 1)) - 1;
    localparam int YMIN = -(1 << (DATA_W - 1));

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] RESP    = 2'd2;

    localparam logic [6:0] F_WR_IN  = 7'd0;
    localparam logic [6:0] F_WR_K   = 7'd1;
    localparam logic [6:0] F_LEN    = 7'd2;
    localparam logic [6:0] F_BIAS   = 7'd3;
    localparam logic [6:0] F_INOFF  = 7'd4;
    localparam logic [6:0] F_QUANT  = 7'd5;
    localparam logic [6:0] F_START  = 7'd6;
    localparam logic [6:0] F_RD_OUT = 7'd7;
    localparam logic [6:0] F_RD_IN  = 7'd8;
    localparam logic [6:0] F_RD_K   = 7'd9;

    logic [1:0]               state;
    logic [LW-1:0]            p;
    logic [LW-1:0]            len;
    logic signed [ACC_W-1:0]  bias;
    logic signed [DATA_W:0]   in_off;
    logic [4:0]               shift;
    logic signed [DATA_W-1:0] out_off;
    logic [31:0]              rsp_data;

    logic [DATA_W-1:0] x_mem [MAX_LEN];
    logic [DATA_W-1:0] w_mem [KERNEL_LEN];
    logic [DATA_W-1:0] y_mem [MAX_LEN];

    logic [6:0]  funct;
    logic [31:0] idx;
    logic        accept;
    logic        in_rng;
    logic        k_rng;
    logic        len_ok;
    logic        cmd_err;
    logic [31:0] cmd_rsp;
    logic [31:0] rd_x;
    logic [31:0] rd_w;
    logic [31:0] rd_y;
    logic        last;
    logic        unused_bits;

    logic [LW-1:0]     lane_pos [LANES];
    logic [LANES-1:0]  lane_en;
    logic [DATA_W-1:0] y_lane [LANES];

    assign funct       = cmd_payload_function_id[9:3];
    assign idx         = cmd_payload_inputs_0;
    assign unused_bits = ^cmd_payload_function_id[2:0];

    assign cmd_ready = reset & (state == IDLE) & ~rsp_valid;
    assign accept    = cmd_valid & cmd_ready;
    assign in_rng    = idx < 32'(MAX_LEN / 4);
    assign k_rng     = idx < 32'(KERNEL_LEN / 4);
    assign len_ok    = (idx != 32'd0) && (idx <= 32'(MAX_LEN));
    assign last      = ({1'b0, p} + (LW + 1)'(LANES)) >= {1'b0, len};

    assign rsp_payload_outputs_0 = rsp_data;

    // One output sample; taps outside [0, len) are padding and contribute nothing.
    function automatic logic [DATA_W-1:0] lane_out(input logic [LW-1:0] pos);
        logic signed [ACC_W-1:0]  acc;
        logic signed [ACC_W-1:0]  rnd;
        logic signed [ACC_W-1:0]  sum;
        logic signed [ACC_W-1:0]  shd;
        logic signed [ACC_W+1:0]  q;
        logic signed [LW+1:0]     tap;
        logic signed [DATA_W:0]   xo;
        logic [DATA_W-1:0]        res;
        acc = bias;
        for (int j = 0; j < KERNEL_LEN; j++) begin
            tap = $signed({2'b00, pos}) - (LW + 2)'(P) + (LW + 2)'(j);
            if (!tap[LW+1] && (tap < $signed({2'b00, len}))) begin
                xo  = (DATA_W + 1)'($signed(x_mem[AW'(tap)])) + in_off;
                acc = acc + ACC_W'(xo) * ACC_W'($signed(w_mem[KAW'(j)]));
            end
        end
        rnd = (shift == 5'd0) ? '0 : (ACC_W'(1) << (shift - 5'd1));
        sum = acc + rnd;
        shd = sum >>> shift;
        q   = (ACC_W + 2)'(shd) + (ACC_W + 2)'(out_off);
        if (q > (ACC_W + 2)'(YMAX)) begin
            res = DATA_W'(YMAX);
        end else if (q < (ACC_W + 2)'(YMIN)) begin
            res = DATA_W'(YMIN);
        end else begin
            res = DATA_W'(q);
        end
        return res;
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_pos[l] = p + LW'(l);
            lane_en[l]  = lane_pos[l] < len;
            y_lane[l]   = lane_out(lane_pos[l]);
        end
    end

    always_comb begin
        rd_x = '0;
        rd_w = '0;
        rd_y = '0;
        for (int k = 0; k < 4; k++) begin
            rd_x[DATA_W*k +: DATA_W] = x_mem[AW'(4 * idx + 32'(k))];
            rd_y[DATA_W*k +: DATA_W] = y_mem[AW'(4 * idx + 32'(k))];
            rd_w[DATA_W*k +: DATA_W] = w_mem[KAW'(4 * idx + 32'(k))];
        end
    end

    always_comb begin
        cmd_rsp = '0;
        cmd_err = 1'b0;
        unique case (funct)
            F_WR_IN:  cmd_err = !in_rng;
            F_WR_K:   cmd_err = !k_rng;
            F_LEN: begin
                cmd_err = !len_ok;
                cmd_rsp = idx;
            end
            F_BIAS, F_INOFF, F_QUANT: cmd_rsp = '0;
            F_START:  cmd_rsp = 32'(len);
            F_RD_OUT: cmd_rsp = in_rng ? rd_y : '0;
            F_RD_IN:  cmd_rsp = in_rng ? rd_x : '0;
            F_RD_K:   cmd_rsp = k_rng ? rd_w : '0;
            default:  cmd_err = 1'b1;
        endcase
        if (cmd_err) begin
            cmd_rsp = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            p         <= '0;
            len       <= '0;
            bias      <= '0;
            in_off    <= (DATA_W + 1)'(1 << (DATA_W - 1));
            shift     <= '0;
            out_off   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (funct == F_START) begin
                            state <= COMPUTE;
                            p     <= '0;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= cmd_rsp;
                        end
                        if (!cmd_err) begin
                            unique case (funct)
                                F_LEN:   len <= LW'(idx);
                                F_BIAS:  bias <= idx;
                                F_INOFF: in_off <= idx[DATA_W:0];
                                F_QUANT: begin
                                    shift   <= idx[4:0];
                                    out_off <= cmd_payload_inputs_1[DATA_W-1:0];
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                COMPUTE: begin
                    p <= p + LW'(LANES);
                    if (last) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= 32'(len);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffers carry no reset; only accepted, in-range writes touch them.
    always_ff @(posedge clk) begin
        if (accept && funct == F_WR_IN && in_rng) begin
            for (int k = 0; k < 4; k++) begin
                x_mem[AW'(4 * idx + 32'(k))] <= cmd_payload_inputs_1[DATA_W*k +: DATA_W];
            end
        end
        if (accept && funct == F_WR_K && k_rng) begin
            for (int k = 0; k < 4; k++) begin
                w_mem[KAW'(4 * idx + 32'(k))] <= cmd_payload_inputs_1[DATA_W*k +: DATA_W];
            end
        end
        if (reset && state == COMPUTE) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_en[l]) begin
                    y_mem[AW'(lane_pos[l])] <= y_lane[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_cfu_conv1d_engine.sv
// tb_cfu_conv1d_engine: self-checking bench for cfu_conv1d_engine.
// Drives CFU commands and compares responses against a behavioural conv model.
module tb_cfu_conv1d_engine;

    localparam int MAX_LEN = 1024;
    localparam int KL      = 8;
    localparam int LANES   = 8;
    localparam int P       = KL / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  fid = '0;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;
    int last_wait = 0;

    int xm [MAX_LEN];
    int wm [KL];
    int ym [MAX_LEN];
    bit yk [MAX_LEN];
    int m_len, m_bias, m_in_off, m_shift, m_out_off;

    always #5 clk = ~clk;

    cfu_conv1d_engine dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic void model_reset();
        m_len = 0;
        m_bias = 0;
        m_in_off = 128;
        m_shift = 0;
        m_out_off = 0;
        for (int i = 0; i < MAX_LEN; i++) yk[i] = 1'b0;
    endfunction

    function automatic int ref_y(int i);
        longint acc;
        longint q;
        int t;
        acc = m_bias;
        for (int j = 0; j < KL; j++) begin
            t = i - P + j;
            if (t >= 0 && t < m_len) acc += longint'(xm[t] + m_in_off) * wm[j];
        end
        if (m_shift > 0) acc += longint'(1) << (m_shift - 1);
        q = (acc >>> m_shift) + m_out_off;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    function automatic void run_model();
        for (int i = 0; i < m_len; i++) begin
            ym[i] = ref_y(i);
            yk[i] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] xword(int idx);
        logic [31:0] e;
        for (int k = 0; k < 4; k++) e[8*k +: 8] = 8'(xm[4*idx+k]);
        return e;
    endfunction

    function automatic void yword(int idx, output logic [31:0] e, output logic [31:0] m);
        e = '0;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (yk[4*idx+k]) begin
                e[8*k +: 8] = 8'(ym[4*idx+k]);
                m[8*k +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic do_cmd(input logic [6:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        fid = {f, 3'b000};
        in0 = a;
        in1 = b;
        rsp_ready = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout funct=%0d", f);
            cmd_valid = 1'b0;
            r = '1;
            lat = -1;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 300) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout funct=%0d", f);
        end
        r = rsp_data;
    endtask

    task automatic wr_in(int idx, logic [31:0] word);
        logic [31:0] r;
        int l;
        do_cmd(7'd0, 32'(idx), word, r, l);
        if (idx >= 0 && idx < MAX_LEN / 4)
            for (int k = 0; k < 4; k++) xm[4*idx+k] = int'($signed(word[8*k +: 8]));
    endtask

    task automatic wr_k(int idx, logic [31:0] word);
        logic [31:0] r;
        int l;
        do_cmd(7'd1, 32'(idx), word, r, l);
        if (idx >= 0 && idx < KL / 4)
            for (int k = 0; k < 4; k++) wm[4*idx+k] = int'($signed(word[8*k +: 8]));
    endtask

    task automatic set_len(int v);
        logic [31:0] r;
        int l;
        do_cmd(7'd2, 32'(v), 32'd0, r, l);
        if (v > 0 && v <= MAX_LEN) m_len = v;
    endtask

    task automatic set_params(int b, int io, int s, int oo);
        logic [31:0] r;
        int l;
        do_cmd(7'd3, 32'(b), 32'd0, r, l);
        do_cmd(7'd4, 32'(io), 32'd0, r, l);
        do_cmd(7'd5, 32'(s), 32'(oo), r, l);
        m_bias = b;
        m_in_off = io;
        m_shift = s;
        m_out_off = oo;
    endtask

    task automatic start(output logic [31:0] r, output int lat);
        do_cmd(7'd6, 32'd0, 32'd0, r, lat);
        run_model();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int l;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got=%b exp=1", cmd_ready); end
        model_reset();
        start(r, l);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL rst_len got=%h exp=0", r); end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        int l;
        wr_in(0, 32'h03020100);
        wr_in(1, 32'h07060504);
        wr_k(0, 32'h02020202);
        wr_k(1, 32'h02020202);
        set_params(1, 0, 0, 0);
        set_len(8);
        start(r, l);
        checks++;
        if (r !== 32'd8 || l != 2) begin errors++; $display("FAIL basic_start got=%h lat=%0d exp=8 lat=2", r, l); end
        do_cmd(7'd7, 32'd0, 32'd0, r, l);
        checks++;
        if (r !== 32'h2B1F150D) begin errors++; $display("FAIL basic_out0 got=%h exp=2b1f150d", r); end
        do_cmd(7'd7, 32'd1, 32'd0, r, l);
        checks++;
        if (r !== 32'h33373939) begin errors++; $display("FAIL basic_out1 got=%h exp=33373939", r); end
        do_cmd(7'd9, 32'd1, 32'd0, r, l);
        checks++;
        if (r !== 32'h02020202) begin errors++; $display("FAIL basic_rdk got=%h exp=02020202", r); end
    endtask

    task automatic test_saturation();
        logic [31:0] r;
        int l;
        wr_in(0, 32'h7F7F7F7F);
        wr_in(1, 32'h7F7F7F7F);
        wr_k(0, 32'h7F7F7F7F);
        wr_k(1, 32'h7F7F7F7F);
        set_params(0, 0, 0, 0);
        set_len(8);
        start(r, l);
        for (int w = 0; w < 2; w++) begin
            do_cmd(7'd7, 32'(w), 32'd0, r, l);
            checks++;
            if (r !== 32'h7F7F7F7F) begin errors++; $display("FAIL sat_hi w=%0d got=%h exp=7f7f7f7f", w, r); end
        end
        set_params(0, 0, 16, 0);
        start(r, l);
        do_cmd(7'd7, 32'd1, 32'd0, r, l);
        checks++;
        if (r[7:0] !== 8'd2) begin errors++; $display("FAIL sat_round got=%h exp=02", r[7:0]); end
        set_params(-1000000, 0, 0, 0);
        start(r, l);
        for (int w = 0; w < 2; w++) begin
            do_cmd(7'd7, 32'(w), 32'd0, r, l);
            checks++;
            if (r !== 32'h80808080) begin errors++; $display("FAIL sat_lo w=%0d got=%h exp=80808080", w, r); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        wr_in(3, 32'hA55A01FE);
        exp = xword(3);
        @(negedge clk);
        cmd_valid = 1'b1;
        fid = {7'd8, 3'b000};
        in0 = 32'd3;
        in1 = 32'd0;
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got=%b exp=1", cmd_ready); end
        @(negedge clk);
        fid = {7'd3, 3'b000};
        in0 = 32'd7;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
                errors++;
                $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, rsp_valid, rsp_data, exp);
            end
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=0", c, cmd_ready); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got=%b/%b exp=0/1", rsp_valid, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        m_bias = 7;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL bp_second got=%b/%h exp=1/0", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_errors();
        logic [31:0] r;
        logic [31:0] exp;
        int l;
        set_len(8);
        do_cmd(7'd2, 32'h401, 32'd0, r, l);
        checks++;
        if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL err_len_big got=%h exp=ffffffff", r); end
        do_cmd(7'd2, 32'd0, 32'd0, r, l);
        checks++;
        if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL err_len_zero got=%h exp=ffffffff", r); end
        start(r, l);
        checks++;
        if (r !== 32'd8) begin errors++; $display("FAIL err_old_len got=%h exp=8", r); end
        exp = xword(0);
        do_cmd(7'd0, 32'd256, 32'hDEADBEEF, r, l);
        checks++;
        if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL err_wr_idx got=%h exp=ffffffff", r); end
        do_cmd(7'd8, 32'd0, 32'd0, r, l);
        checks++;
        if (r !== exp) begin errors++; $display("FAIL err_wr_nochg got=%h exp=%h", r, exp); end
        do_cmd(7'd1, 32'd2, 32'hDEADBEEF, r, l);
        checks++;
        if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL err_wk_idx got=%h exp=ffffffff", r); end
        do_cmd(7'h7F, 32'd0, 32'd0, r, l);
        checks++;
        if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL err_funct got=%h exp=ffffffff", r); end
        do_cmd(7'd7, 32'd300, 32'd0, r, l);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL err_rd_idx got=%h exp=0", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int l;
        for (int i = 0; i < 4; i++) begin
            do_cmd(7'(3 + (i % 3)), $urandom_range(0, 100), 32'd0, r, l);
            checks++;
            if (r !== 32'd0 || l != 1 || last_wait != 0) begin
                errors++;
                $display("FAIL b2b i=%0d got=%h lat=%0d wait=%0d exp=0/1/0", i, r, l, last_wait);
            end
        end
        do_cmd(7'd2, 32'd40, 32'd0, r, l);
        checks++;
        if (r !== 32'd40 || l != 1) begin errors++; $display("FAIL b2b_len got=%h lat=%0d exp=28/1", r, l); end
        m_len = 40;
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] e;
        logic [31:0] m;
        int l;
        int n;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 64));
            for (int w = 0; w < (n + 3) / 4; w++) wr_in(w, $urandom());
            wr_k(0, $urandom());
            wr_k(1, $urandom());
            set_params(int'($urandom_range(0, 10000)) - 5000,
                       int'($urandom_range(0, 255)) - 128,
                       int'($urandom_range(0, 12)),
                       int'($urandom_range(0, 255)) - 128);
            set_len(n);
            start(r, l);
            checks++;
            if (r !== 32'(n) || l != (n + LANES - 1) / LANES + 1) begin
                errors++;
                $display("FAIL rnd_start it=%0d got=%h lat=%0d exp=%h lat=%0d", it, r, l, n, (n + 7) / 8 + 1);
            end
            for (int w = 0; w < (n + 3) / 4; w++) begin
                yword(w, e, m);
                do_cmd(7'd7, 32'(w), 32'd0, r, l);
                checks++;
                if ((r & m) !== e) begin
                    errors++;
                    $display("FAIL rnd_out it=%0d w=%0d got=%h exp=%h mask=%h", it, w, r, e, m);
                end
            end
        end
    endtask

    task automatic test_partial();
        logic [31:0] r;
        logic [31:0] e;
        logic [31:0] m;
        int l;
        for (int w = 0; w < 4; w++) wr_in(w, $urandom());
        wr_k(0, $urandom());
        wr_k(1, $urandom());
        set_params(100, 3, 5, -2);
        set_len(16);
        start(r, l);
        set_params(-3000, -20, 6, 9);
        set_len(12);
        start(r, l);
        checks++;
        if (r !== 32'd12 || l != 3) begin errors++; $display("FAIL part_start got=%h lat=%0d exp=c/3", r, l); end
        for (int w = 2; w < 4; w++) begin
            yword(w, e, m);
            do_cmd(7'd7, 32'(w), 32'd0, r, l);
            checks++;
            if ((r & m) !== e) begin errors++; $display("FAIL part_out w=%0d got=%h exp=%h", w, r, e); end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        logic [31:0] e;
        logic [31:0] m;
        int l;
        set_len(1024);
        @(negedge clk);
        cmd_valid = 1'b1;
        fid = {7'd6, 3'b000};
        in0 = 32'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (49) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got=%b/%b exp=0/0", rsp_valid, cmd_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst got=%b/%h/%b exp=0/0/0", rsp_valid, rsp_data, cmd_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", cmd_ready); end
        model_reset();
        start(r, l);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL abort_len got=%h exp=0", r); end
        wr_in(0, $urandom());
        wr_in(1, $urandom());
        wr_k(0, 32'h01FF0302);
        wr_k(1, 32'hFE010203);
        set_len(8);
        start(r, l);
        for (int w = 0; w < 2; w++) begin
            yword(w, e, m);
            do_cmd(7'd7, 32'(w), 32'd0, r, l);
            checks++;
            if ((r & m) !== e) begin errors++; $display("FAIL abort_defaults w=%0d got=%h exp=%h", w, r, e); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_random();
        test_partial();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
